universal_shift_register: RTL and testbench

Parametrised successor to the team's single-lane SIPO/PISO shift register. It adds a lane count, a direction select and a selectable peripheral-clock edge. Load-vs-shift collisions have defined priority, and a frame counter flags completion of a full-word transfer. It sits between SPI-style serial pins and the parallel datapath.

---
 rtl/universal_shift_register.sv | 100 ++++++++++
 tb/tb_universal_shift_register.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/universal_shift_register.sv
// universal_shift_register: multi-lane SIPO/PISO shift register with pclk edge select.
// Define SHIFTREG_PCLK_SYNC_EN to pass pclk through a two-flop synchroniser.
module universal_shift_register #(
  parameter int width = 8,
  parameter int lanes = 1,
  parameter int cntw  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pclk,
  input  logic             edge_sel,
  input  logic             dir,
  input  logic             shift_en,
  input  logic             pload,
  input  logic [width-1:0] pdataIn,
  input  logic [lanes-1:0] sdataIn,
  output logic [width-1:0] pdataOut,
  output logic [lanes-1:0] sdataOut,
  output logic [cntw-1:0]  shift_count,
  output logic             frame_done
);

  localparam int frames = width / lanes;
  localparam logic [cntw-1:0] last_cnt = cntw'(frames - 1);

  logic [width-1:0] mem;
  logic [width-1:0] mem_nxt;
  logic             pclk_s;
  logic             pclk_q;
  logic             hit;
  logic             shift_ev;
  logic             last;

`ifdef SHIFTREG_PCLK_SYNC_EN
  logic sync1;
  logic sync2;

  // two-flop synchroniser so pclk may be asynchronous to clk
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= pclk;
      sync2 <= sync1;
    end
  end

  assign pclk_s = sync2;
`else
  assign pclk_s = pclk;
`endif

  // edge_sel picks rising (0) or falling (1) pclk edge
  always_comb begin
    hit = 1'b0;
    if (edge_sel) hit = ~pclk_s & pclk_q;
    else          hit = pclk_s & ~pclk_q;
  end

  // load wins over a coincident edge; that edge is consumed
  assign shift_ev = hit & shift_en & ~pload;
  assign last     = (shift_count == last_cnt);

  // shifted value; bits moved out of the far end are dropped
  always_comb begin
    mem_nxt = mem;
    if (dir) mem_nxt = {sdataIn, mem[width-1:lanes]};
    else     mem_nxt = {mem[width-lanes-1:0], sdataIn};
  end

  // previous pclk level, updated every cycle regardless of load/enable
  always_ff @(posedge clk or posedge reset) begin
    if (reset) pclk_q <= 1'b0;
    else       pclk_q <= pclk_s;
  end

  // register contents: parallel load or shift
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         mem <= '0;
    else if (pload)    mem <= pdataIn;
    else if (shift_ev) mem <= mem_nxt;
  end

  // frame counter; final shift wraps it and raises a one-cycle pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_count <= '0;
      frame_done  <= 1'b0;
    end else begin
      frame_done <= shift_ev & last;
      if (pload)         shift_count <= '0;
      else if (shift_ev) shift_count <= last ? '0 : shift_count + 1'b1;
    end
  end

  assign pdataOut = mem;
  assign sdataOut = dir ? mem[lanes-1:0] : mem[width-1 -: lanes];

endmodule

// File: tb/tb_universal_shift_register.sv
// tb_universal_shift_register: directed + random checks of lanes=1 and lanes=2 builds.
// Reference model works on whole-word arithmetic and a sampled pclk history.
module tb_universal_shift_register;

`ifdef SHIFTREG_PCLK_SYNC_EN
  localparam int dly = 2;
`else
  localparam int dly = 0;
`endif

  logic       clk = 0;
  logic       reset = 1;
  logic       pclk = 0;
  logic       edge_sel = 0;
  logic       dir = 0;
  logic       shift_en = 0;
  logic       pload = 0;
  logic [7:0] pdataIn = 0;
  logic [0:0] sdataIn1 = 0;
  logic [1:0] sdataIn2 = 0;

  logic [7:0] pout1, pout2;
  logic [0:0] sout1;
  logic [1:0] sout2;
  logic [3:0] cnt1, cnt2;
  logic       fd1, fd2;

  int vectors = 0;
  int miscompares = 0;
  int fd1_seen = 0;

  // model state
  logic [7:0] m_mem1, m_mem2;
  int         m_cnt1, m_cnt2;
  logic       m_fd1, m_fd2;
  logic       m_q, h0, h1;

  always #5 clk = ~clk;

  universal_shift_register #(.width(8), .lanes(1), .cntw(4)) u1 (
    .clk(clk), .reset(reset), .pclk(pclk), .edge_sel(edge_sel),
    .dir(dir), .shift_en(shift_en), .pload(pload), .pdataIn(pdataIn),
    .sdataIn(sdataIn1), .pdataOut(pout1), .sdataOut(sout1),
    .shift_count(cnt1), .frame_done(fd1)
  );

  universal_shift_register #(.width(8), .lanes(2), .cntw(4)) u2 (
    .clk(clk), .reset(reset), .pclk(pclk), .edge_sel(edge_sel),
    .dir(dir), .shift_en(shift_en), .pload(pload), .pdataIn(pdataIn),
    .sdataIn(sdataIn2), .pdataOut(pout2), .sdataOut(sout2),
    .shift_count(cnt2), .frame_done(fd2)
  );

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] shf(logic [7:0] m, int l, int s, logic d);
    if (!d) return 8'((m << l) | s);
    return 8'((m >> l) | (s << (8 - l)));
  endfunction

  function automatic logic [7:0] sout_of(logic [7:0] m, int l, logic d);
    if (d) return 8'(m % (1 << l));
    return 8'(m >> (8 - l));
  endfunction

  task automatic model_reset();
    m_mem1 = 0; m_mem2 = 0; m_cnt1 = 0; m_cnt2 = 0;
    m_fd1 = 0; m_fd2 = 0; m_q = 0; h0 = 0; h1 = 0;
  endtask

  task automatic model_tick();
    logic ps, ev;
    ps = (dly == 0) ? pclk : h1;
    h1 = h0;
    h0 = pclk;
    ev = edge_sel ? (!ps && m_q) : (ps && !m_q);
    m_q = ps;
    m_fd1 = 0;
    m_fd2 = 0;
    if (pload) begin
      m_mem1 = pdataIn; m_cnt1 = 0;
      m_mem2 = pdataIn; m_cnt2 = 0;
    end else if (ev && shift_en) begin
      m_mem1 = shf(m_mem1, 1, int'(sdataIn1), dir);
      m_mem2 = shf(m_mem2, 2, int'(sdataIn2), dir);
      m_cnt1++;
      m_cnt2++;
      if (m_cnt1 == 8) begin m_cnt1 = 0; m_fd1 = 1; end
      if (m_cnt2 == 4) begin m_cnt2 = 0; m_fd2 = 1; end
    end
  endtask

  task automatic check_all();
    chk("u1_pdata", 32'(pout1), 32'(m_mem1));
    chk("u1_sdata", 32'(sout1), 32'(sout_of(m_mem1, 1, dir)));
    chk("u1_count", 32'(cnt1), 32'(m_cnt1));
    chk("u1_done", 32'(fd1), 32'(m_fd1));
    chk("u2_pdata", 32'(pout2), 32'(m_mem2));
    chk("u2_sdata", 32'(sout2), 32'(sout_of(m_mem2, 2, dir)));
    chk("u2_count", 32'(cnt2), 32'(m_cnt2));
    chk("u2_done", 32'(fd2), 32'(m_fd2));
  endtask

  task automatic step();
    @(posedge clk);
    if (reset) model_reset();
    else model_tick();
    #1;
    if (fd1) fd1_seen++;
    check_all();
  endtask

  task automatic level(logic v);
    pclk = v;
    repeat (3) step();
  endtask

  task automatic load(logic [7:0] v);
    pdataIn = v;
    pload = 1;
    step();
    pload = 0;
  endtask

  initial begin
    logic [7:0] pat;
    logic [7:0] got;
    logic [7:0] lp;
    model_reset();
    repeat (2) step();
    reset = 0;
    repeat (2) step();

    // async reset mid-cycle with pclk high; no false edge on release
    load(8'h5A);
    pclk = 1;
    edge_sel = 1;
    shift_en = 1;
    #2 reset = 1;
    #1 model_reset();
    chk("rst_pdata", 32'(pout1), 32'h00);
    chk("rst_count", 32'(cnt1), 32'h0);
    chk("rst_done", 32'(fd1), 32'h0);
    check_all();
    step();
    reset = 0;
    repeat (4) step();
    chk("rst_noshift", 32'(pout1), 32'h00);

    // SIPO left, rising edges
    edge_sel = 0; dir = 0; pclk = 0;
    step();
    load(8'h00);
    pat = 8'b10110010;
    fd1_seen = 0;
    for (int i = 7; i >= 0; i--) begin
      sdataIn1 = pat[i];
      level(1);
      level(0);
    end
    chk("sipo_b2", 32'(pout1), 32'hB2);
    chk("sipo_cnt", 32'(cnt1), 32'h0);
    chk("sipo_pulses", 32'(fd1_seen), 32'd1);

    // PISO right, falling edges, LSB first
    load(8'hA5);
    dir = 1; edge_sel = 1;
    level(1);
    fd1_seen = 0;
    got = 0;
    for (int i = 0; i < 8; i++) begin
      got[i] = sout1[0];
      level(0);
      level(1);
    end
    chk("piso_seq", 32'(got), 32'hA5);
    chk("piso_pulses", 32'(fd1_seen), 32'd1);

    // load colliding with a detected rising edge
    dir = 0; edge_sel = 0;
    level(0);
    load(8'hFF);
    sdataIn1 = 0;
    pclk = 1;
    repeat (dly) step();
    pdataIn = 8'h3C;
    pload = 1;
    step();
    pload = 0;
    chk("coll_pdata", 32'(pout1), 32'h3C);
    chk("coll_count", 32'(cnt1), 32'h0);
    repeat (3) step();
    chk("coll_noreplay", 32'(pout1), 32'h3C);
    level(0);
    level(1);
    chk("coll_next", 32'(pout1), 32'h78);

    // two lanes, left
    level(0);
    load(8'hFF);
    lp = 8'b11011000;
    for (int i = 0; i < 4; i++) begin
      sdataIn2 = lp[7 - 2*i -: 2];
      level(1);
      level(0);
      if (i == 1) chk("l2_sout", 32'(sout2), 32'h3);
    end
    chk("l2_d8", 32'(pout2), 32'hD8);

    // disabled edges leave state untouched; then shift latency
    load(8'h00);
    shift_en = 0;
    sdataIn1 = 1;
    for (int i = 0; i < 3; i++) begin
      level(1);
      level(0);
    end
    chk("dis_pdata", 32'(pout1), 32'h00);
    chk("dis_count", 32'(cnt1), 32'h0);
    shift_en = 1;
    pclk = 1;
    for (int k = 1; k <= 4; k++) begin
      step();
      chk("lat_pdata", 32'(pout1), (k > dly) ? 32'h01 : 32'h00);
    end

    // randomized phase
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 1) == 0) pclk = ~pclk;
      if ($urandom_range(0, 7) == 0) dir = ~dir;
      if ($urandom_range(0, 15) == 0) edge_sel = ~edge_sel;
      shift_en = ($urandom_range(0, 3) != 0);
      pload = ($urandom_range(0, 11) == 0);
      pdataIn = 8'($urandom);
      sdataIn1 = 1'($urandom);
      sdataIn2 = 2'($urandom);
      if ($urandom_range(0, 99) == 0) begin
        #2 reset = 1;
        #1 model_reset();
        check_all();
        step();
        reset = 0;
      end else begin
        step();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
